// File: rtl/time_keeper_if.sv
// Control and time-of-day signal bundle between the alarm clock UI and time_keeper.
// The master drives the run/set controls and observes the time fields; the
// slave (time_keeper) does the reverse.
interface time_keeper_if;
  logic       run;
  logic       incMin;
  logic       incHour;
  logic       clearSec;
  logic [6:0] seconds;
  logic [6:0] minutes;
  logic [6:0] hours;
  logic       secTick;
  logic       pm;

  modport master (
    output run, incMin, incHour, clearSec,
    input  seconds, minutes, hours, secTick, pm
  );

  modport slave (
    input  run, incMin, incHour, clearSec,
    output seconds, minutes, hours, secTick, pm
  );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: divides clk down to a 1 Hz tick and keeps binary seconds,
// minutes and hours, with user set-time pulses for minutes/hours and a
// seconds clear. Optional macro TWELVE_HOUR_EN switches hours to a 1..12
// sequence with a PM flag; without it hours run 0..23 and pm is tied low.
module time_keeper #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input logic         clk,
  input logic         rst_n,
  time_keeper_if.slave tk
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef TWELVE_HOUR_EN
  localparam logic [6:0] HOUR_RESET = 7'd12;
`else
  localparam logic [6:0] HOUR_RESET = 7'd0;
`endif

  logic [PW-1:0] presc;
  logic [6:0]    sec_q;
  logic [6:0]    min_q;
  logic [6:0]    hour_q;
  logic          tick_q;
  logic          inc_min_prev;
  logic          inc_hour_prev;

  logic          rise_min;
  logic          rise_hour;
  logic          tick;
  logic          sec_wrap;
  logic          min_carry;
  logic          min_step;
  logic          hour_step;
  logic [6:0]    sec_next;
  logic [6:0]    min_next;
  logic [6:0]    hour_next;

  // A tick is suppressed both while frozen and while seconds are being cleared.
  assign rise_min  = tk.incMin & ~inc_min_prev;
  assign rise_hour = tk.incHour & ~inc_hour_prev;
  assign tick      = tk.run & ~tk.clearSec & (presc == PRESC_LAST);
  assign sec_wrap  = tick & (sec_q == 7'd59);
  // A manual minute increment swallows the seconds carry, so it cannot ripple on.
  assign min_carry = sec_wrap & ~rise_min & (min_q == 7'd59);
  assign min_step  = rise_min | sec_wrap;
  assign hour_step = rise_hour | min_carry;

  // Next-value computation for the seconds and minutes fields.
  always_comb begin
    sec_next = sec_q;
    min_next = min_q;
    if (tk.clearSec)
      sec_next = 7'd0;
    else if (tick)
      sec_next = (sec_q == 7'd59) ? 7'd0 : sec_q + 7'd1;
    if (min_step)
      min_next = (min_q == 7'd59) ? 7'd0 : min_q + 7'd1;
  end

`ifdef TWELVE_HOUR_EN
  logic pm_q;
  logic pm_next;

  // Twelve-hour sequence: 11 -> 12 flips AM/PM, 12 -> 1 keeps it.
  always_comb begin
    hour_next = hour_q;
    pm_next   = pm_q;
    if (hour_step) begin
      if (hour_q == 7'd12) begin
        hour_next = 7'd1;
      end else begin
        hour_next = hour_q + 7'd1;
        if (hour_q == 7'd11)
          pm_next = ~pm_q;
      end
    end
  end

  // AM/PM flag register; reset lands on 12 AM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pm_q <= 1'b0;
    else
      pm_q <= pm_next;
  end

  assign tk.pm = pm_q;
`else
  // Twenty-four-hour sequence wrapping 23 -> 0.
  always_comb begin
    hour_next = hour_q;
    if (hour_step)
      hour_next = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
  end

  assign tk.pm = 1'b0;
`endif

  // Prescaler: clear wins, otherwise counts while running and wraps on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (tk.clearSec)
      presc <= '0;
    else if (tk.run)
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
  end

  // Edge-detect history; reset high so a level held through reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_min_prev  <= 1'b1;
      inc_hour_prev <= 1'b1;
    end else begin
      inc_min_prev  <= tk.incMin;
      inc_hour_prev <= tk.incHour;
    end
  end

  // Time-of-day registers and the one-cycle seconds pulse, all updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= 7'd0;
      min_q  <= 7'd0;
      hour_q <= HOUR_RESET;
      tick_q <= 1'b0;
    end else begin
      sec_q  <= sec_next;
      min_q  <= min_next;
      hour_q <= hour_next;
      tick_q <= tick;
    end
  end

  assign tk.seconds = sec_q;
  assign tk.minutes = min_q;
  assign tk.hours   = hour_q;
  assign tk.secTick = tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with TICKS_PER_SEC=4. Expected states
// are queued as stimulus is applied and popped when the DUT is sampled.
// Build with TWELVE_HOUR_EN defined to exercise the 12-hour sequence.
module tb_time_keeper;

`ifdef TWELVE_HOUR_EN
  localparam logic [6:0] H0 = 7'd12;
`else
  localparam logic [6:0] H0 = 7'd0;
`endif

  typedef struct {
    string       name;
    logic [22:0] value;
  } exp_t;

  logic clk;
  logic rst_n;
  time_keeper_if tk();

  exp_t        exp_q[$];
  exp_t        ent;
  logic [22:0] got;
  int          n_cmp;
  int          n_err;
  int          cnt;

  time_keeper #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tk    (tk)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] mk(input int h, input int m, input int s, input bit t, input bit p);
    mk = {7'(h), 7'(m), 7'(s), t, p};
  endfunction

  function automatic logic [22:0] snap();
    snap = {tk.hours, tk.minutes, tk.seconds, tk.secTick, tk.pm};
  endfunction

  function automatic string fmt(input logic [22:0] v);
    fmt = $sformatf("%0d:%0d:%0d secTick=%0b pm=%0b", v[22:16], v[15:9], v[8:2], v[1], v[0]);
  endfunction

  task automatic push_exp(input string name, input int h, input int m, input int s, input bit t, input bit p);
    exp_t e;
    e.name  = name;
    e.value = mk(h, m, s, t, p);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      tk.incMin = 1'b1; step(1);
      tk.incMin = 1'b0; step(1);
    end
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      tk.incHour = 1'b1; step(1);
      tk.incHour = 1'b0; step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tk.run = 1'b0; tk.incMin = 1'b0; tk.incHour = 1'b0; tk.clearSec = 1'b0;
    step(3);
    rst_n = 1'b1;
    push_exp("reset_state", H0, 0, 0, 0, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("reset_idle", H0, 0, 0, 0, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
  endtask

  task automatic test_tick_rate();
    tk.run = 1'b1;
    push_exp("pre_first_tick", H0, 0, 0, 0, 0);
    step(3);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("first_tick", H0, 0, 1, 1, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("tick_one_cycle", H0, 0, 1, 0, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    cnt = 0;
    for (int i = 0; i < 955; i++) begin
      step(1);
      if (tk.secTick) cnt++;
    end
    n_cmp++;
    if (cnt !== 239) begin n_err++; $display("FAIL tick_count: got %0d pulses, expected 239", cnt); end
    push_exp("after_240_ticks", H0, 4, 0, 1, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.run = 1'b0;
  endtask

  task automatic test_run_freeze();
    tk.run = 1'b1;
    step(2);
    tk.run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tk.secTick) cnt++;
    end
    n_cmp++;
    if (cnt !== 0) begin n_err++; $display("FAIL freeze_tick: got %0d pulses, expected 0", cnt); end
    push_exp("frozen_state", H0, 4, 0, 0, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.run = 1'b1;
    push_exp("resume_no_tick", H0, 4, 0, 0, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("resume_tick", H0, 4, 1, 1, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.run = 1'b0;
    step(1);
  endtask

  task automatic test_min_wrap_hold();
    pulse_min(55);
    push_exp("min_preload", H0, 59, 1, 0, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("min_wrap_no_carry", H0, 0, 1, 0, 0);
    pulse_min(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.incMin = 1'b1;
    push_exp("hold_first_edge", H0, 1, 1, 0, 0);
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("hold_20_cycles", H0, 1, 1, 0, 0);
    step(19);
    tk.incMin = 1'b0;
    step(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
  endtask

  task automatic test_coincident();
    pulse_min(9);
    tk.clearSec = 1'b1; step(1); tk.clearSec = 1'b0;
    tk.run = 1'b1;
    push_exp("sec59_preload", H0, 10, 59, 1, 0);
    step(236);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    step(3);
    tk.incMin = 1'b1;
    push_exp("carry_and_incmin", H0, 11, 0, 1, 0);
    step(1);
    tk.incMin = 1'b0;
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    step(236);
    step(3);
    tk.clearSec = 1'b1;
    push_exp("clearsec_on_tick", H0, 11, 0, 0, 0);
    step(1);
    tk.clearSec = 1'b0;
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("clearsec_presc_zero", H0, 11, 1, 1, 0);
    step(4);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.run = 1'b0;
    step(1);
  endtask

`ifdef TWELVE_HOUR_EN
  task automatic test_twelve_hour();
    pulse_hour(11);
    push_exp("hour_11_am", 11, 11, 1, 0, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    pulse_min(48);
    tk.clearSec = 1'b1; step(1); tk.clearSec = 1'b0;
    tk.run = 1'b1;
    step(236 + 3);
    push_exp("noon_rollover", 12, 0, 0, 1, 1);
    step(1);
    tk.run = 1'b0;
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("inchour_12_to_1", 1, 0, 0, 0, 1);
    pulse_hour(1);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("inchour_11_to_12_am", 12, 0, 0, 0, 0);
    pulse_hour(11);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
  endtask
`else
  task automatic test_midnight();
    pulse_hour(23);
    pulse_min(48);
    tk.clearSec = 1'b1; step(1); tk.clearSec = 1'b0;
    tk.run = 1'b1;
    push_exp("preload_235959", 23, 59, 59, 1, 0);
    step(236);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    push_exp("midnight_rollover", 0, 0, 0, 1, 0);
    step(4);
    tk.run = 1'b0;
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    step(1);
  endtask

  task automatic test_both_inc();
    tk.incMin = 1'b1; tk.incHour = 1'b1;
    push_exp("both_inc_together", 1, 1, 0, 0, 0);
    step(1);
    tk.incMin = 1'b0; tk.incHour = 1'b0;
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    step(1);
    push_exp("hour_wrap_23_to_0", 0, 1, 0, 0, 0);
    pulse_hour(23);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
  endtask
`endif

  task automatic test_async_reset();
    tk.run = 1'b1;
    step(5);
    rst_n = 1'b0;
    tk.run = 1'b0; tk.incMin = 1'b1; tk.incHour = 1'b1;
    #1;
    push_exp("async_reset_now", H0, 0, 0, 0, 0);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    step(2);
    rst_n = 1'b1;
    push_exp("held_inc_across_reset", H0, 0, 0, 0, 0);
    step(3);
    ent = exp_q.pop_front(); got = snap(); n_cmp++;
    if (got !== ent.value) begin n_err++; $display("FAIL %s: got %s, expected %s", ent.name, fmt(got), fmt(ent.value)); end
    tk.incMin = 1'b0; tk.incHour = 1'b0;
    step(1);
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_tick_rate();
    test_run_freeze();
    test_min_wrap_hold();
    test_coincident();
`ifdef TWELVE_HOUR_EN
    test_twelve_hour();
`else
    test_midnight();
    test_both_inc();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
